// File: rtl/axi_sram_responder.sv
// AXI4 slave terminating one burst at a time into a flop-based word memory.
// Define AXI_SRAM_STATS_EN to add saturating beat/error counter outputs.
module axi_sram_responder #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1,
  parameter int MEM_WORDS      = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
  input  logic [7:0]                  aw_len,
  input  logic [2:0]                  aw_size,
  input  logic [1:0]                  aw_burst,
  input  logic [AXI_USER_WIDTH-1:0]   aw_user,
  input  logic                        aw_valid,
  output logic                        aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  input  logic                        w_last,
  input  logic [AXI_USER_WIDTH-1:0]   w_user,
  input  logic                        w_valid,
  output logic                        w_ready,
  output logic [AXI_ID_WIDTH-1:0]     b_id,
  output logic [1:0]                  b_resp,
  output logic [AXI_USER_WIDTH-1:0]   b_user,
  output logic                        b_valid,
  input  logic                        b_ready,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
  input  logic [7:0]                  ar_len,
  input  logic [2:0]                  ar_size,
  input  logic [1:0]                  ar_burst,
  input  logic [AXI_USER_WIDTH-1:0]   ar_user,
  input  logic                        ar_valid,
  output logic                        ar_ready,
  output logic [AXI_ID_WIDTH-1:0]     r_id,
  output logic [AXI_DATA_WIDTH-1:0]   r_data,
  output logic [1:0]                  r_resp,
  output logic                        r_last,
  output logic [AXI_USER_WIDTH-1:0]   r_user,
  output logic                        r_valid,
  input  logic                        r_ready
`ifdef AXI_SRAM_STATS_EN
  ,
  output logic [31:0]                 wr_beats_o,
  output logic [31:0]                 rd_beats_o,
  output logic [15:0]                 err_cnt_o
`endif
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_WORDS * 4);
  localparam logic [IDX_W-1:0] IDX_MAX     = IDX_W'(MEM_WORDS - 1);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [1:0]       BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [AXI_ADDR_WIDTH-1:0] addr);
    return (size != 3'd2) || burst[1] || (addr >= MEM_BYTES);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  state_e                    state_q, state_d;
  logic                      prio_wr_q, prio_wr_d;
  logic                      idle_rdy_q, idle_rdy_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      incr_q, incr_d;
  logic                      err_q, err_d;
  logic                      w_ready_q, w_ready_d;
  logic                      b_valid_q, b_valid_d;
  logic [AXI_ID_WIDTH-1:0]   b_id_q, b_id_d;
  logic [1:0]                b_resp_q, b_resp_d;
  logic                      r_valid_q, r_valid_d;
  logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]                r_resp_q, r_resp_d;
  logic                      r_last_q, r_last_d;

  logic             aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic             mem_we, wrap_err, beat_last, beat_err;
  logic             aw_err, ar_err;
  logic [IDX_W-1:0] idx_nxt, aw_idx, ar_idx;
  logic             unused_inputs;

  // The loser of a simultaneous request sees ready low in the same cycle.
  assign aw_ready = idle_rdy_q & (prio_wr_q | ~ar_valid);
  assign ar_ready = idle_rdy_q & (~prio_wr_q | ~aw_valid);
  assign w_ready  = w_ready_q;
  assign b_valid  = b_valid_q;
  assign b_id     = b_id_q;
  assign b_resp   = b_resp_q;
  assign b_user   = '0;
  assign r_valid  = r_valid_q;
  assign r_id     = r_id_q;
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;
  assign r_last   = r_last_q;
  assign r_user   = '0;

  assign aw_hs = aw_valid & aw_ready;
  assign ar_hs = ar_valid & ar_ready;
  assign w_hs  = w_valid & w_ready_q;
  assign b_hs  = b_valid_q & b_ready;
  assign r_hs  = r_valid_q & r_ready;

  assign aw_idx    = aw_addr[IDX_W+1:2];
  assign ar_idx    = ar_addr[IDX_W+1:2];
  assign aw_err    = req_err(aw_size, aw_burst, aw_addr);
  assign ar_err    = req_err(ar_size, ar_burst, ar_addr);
  assign idx_nxt   = incr_q ? idx_q + 1'b1 : idx_q;
  assign wrap_err  = incr_q && (idx_q == IDX_MAX);
  assign beat_last = (cnt_q == len_q);
  assign beat_err  = err_q | wrap_err;

  assign unused_inputs = ^{aw_user, w_user, ar_user};

  always_comb begin
    state_d    = state_q;
    prio_wr_d  = prio_wr_q;
    idle_rdy_d = idle_rdy_q;
    id_d       = id_q;
    idx_d      = idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    incr_d     = incr_q;
    err_d      = err_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_id_d     = b_id_q;
    b_resp_d   = b_resp_q;
    r_valid_d  = r_valid_q;
    r_id_d     = r_id_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    r_last_d   = r_last_q;
    mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_rdy_d = 1'b1;
        if (aw_hs) begin
          state_d    = WDATA;
          idle_rdy_d = 1'b0;
          prio_wr_d  = ~prio_wr_q;
          id_d       = aw_id;
          idx_d      = aw_idx;
          len_d      = aw_len;
          cnt_d      = 8'd0;
          incr_d     = (aw_burst == BURST_INCR);
          err_d      = aw_err;
          w_ready_d  = 1'b1;
        end else if (ar_hs) begin
          state_d    = RDATA;
          idle_rdy_d = 1'b0;
          prio_wr_d  = ~prio_wr_q;
          id_d       = ar_id;
          idx_d      = ar_idx;
          len_d      = ar_len;
          cnt_d      = 8'd0;
          incr_d     = (ar_burst == BURST_INCR);
          err_d      = ar_err;
          r_valid_d  = 1'b1;
          r_id_d     = ar_id;
          r_data_d   = ar_err ? '0 : mem_q[ar_idx];
          r_resp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
          r_last_d   = (ar_len == 8'd0);
        end
      end
      WDATA: begin
        if (w_hs) begin
          mem_we = ~err_q;
          if (beat_last) begin
            state_d   = WRESP;
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            b_id_d    = id_q;
            b_resp_d  = (err_q | ~w_last) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
            idx_d = idx_nxt;
            err_d = beat_err | w_last;
          end
        end
      end
      WRESP: begin
        if (b_hs) begin
          state_d    = IDLE;
          b_valid_d  = 1'b0;
          idle_rdy_d = 1'b1;
        end
      end
      RDATA: begin
        if (r_hs) begin
          if (r_last_q) begin
            state_d    = IDLE;
            r_valid_d  = 1'b0;
            r_last_d   = 1'b0;
            idle_rdy_d = 1'b1;
          end else begin
            cnt_d    = cnt_q + 8'd1;
            idx_d    = idx_nxt;
            err_d    = beat_err;
            r_data_d = beat_err ? '0 : mem_q[idx_nxt];
            r_resp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
            r_last_d = ((cnt_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_wr_q  <= 1'b1;
      idle_rdy_q <= 1'b0;
      id_q       <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      incr_q     <= 1'b0;
      err_q      <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= '0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_wr_q  <= prio_wr_d;
      idle_rdy_q <= idle_rdy_d;
      id_q       <= id_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      incr_q     <= incr_d;
      err_q      <= err_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_id_q     <= b_id_d;
      b_resp_q   <= b_resp_d;
      r_valid_q  <= r_valid_d;
      r_id_q     <= r_id_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
    end
  end

  // Memory is deliberately left out of reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) mem_q[idx_q][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

`ifdef AXI_SRAM_STATS_EN
  logic [31:0] wr_beats_q, wr_beats_d, rd_beats_q, rd_beats_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != '1)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    wr_beats_d = sat_inc32(wr_beats_q, w_hs);
    rd_beats_d = sat_inc32(rd_beats_q, r_hs);
    err_cnt_d  = sat_inc16(err_cnt_q,
                           (b_hs && (b_resp_q == RESP_SLVERR)) ||
                           (r_hs && r_last_q && (r_resp_q == RESP_SLVERR)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_beats_q <= '0;
      rd_beats_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      wr_beats_q <= wr_beats_d;
      rd_beats_q <= rd_beats_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign wr_beats_o = wr_beats_q;
  assign rd_beats_o = rd_beats_q;
  assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: transaction table plus hand-written
// arbitration, backpressure and reset-abort sequences.
module tb_axi_sram_responder;

  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLV  = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  aw_id = '0;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = '0;
  logic [1:0]  aw_burst = '0;
  logic [0:0]  aw_user = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_last = 1'b0;
  logic [0:0]  w_user = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic [0:0]  b_user;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [3:0]  ar_id = '0;
  logic [31:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = '0;
  logic [1:0]  ar_burst = '0;
  logic [0:0]  ar_user = '0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [0:0]  r_user;
  logic        r_valid;
  logic        r_ready = 1'b0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  axi_sram_responder dut (
    .clk(clk), .rst_n(rst_n),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user),
    .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_user(ar_user), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
    .r_valid(r_valid), .r_ready(r_ready)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] d0;       // write data base, or expected read data base
    logic [31:0] step;     // per-beat increment of d0
    bit          bad_last;
    logic [1:0]  bresp;
    int          err_from; // first read beat expected as SLVERR (256 = none)
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    aw_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      #1;
      if (aw_ready) break;
      @(posedge clk); #1;
    end
    check("aw_accept", 32'(n < 50), 32'd1);
    if (n < 50) begin @(posedge clk); #1; end
    aw_valid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    ar_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      #1;
      if (ar_ready) break;
      @(posedge clk); #1;
    end
    check("ar_accept", 32'(n < 50), 32'd1);
    if (n < 50) begin @(posedge clk); #1; end
    ar_valid = 1'b0;
  endtask

  task automatic do_w(input logic [7:0] len, input logic [31:0] d0, input logic [31:0] step,
                      input logic [3:0] strb, input bit bad_last);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      w_data  = d0 + 32'(i) * step;
      w_strb  = strb;
      w_last  = (i == int'(len)) ^ bad_last;
      w_valid = 1'b1;
      for (n = 0; n < 50; n++) begin
        if (w_ready) break;
        @(posedge clk); #1;
      end
      check("w_accept", 32'(n < 50), 32'd1);
      if (n >= 50) break;
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] id, input logic [1:0] resp);
    int n;
    b_ready = 1'b1;
    for (n = 0; n < 50; n++) begin
      if (b_valid) break;
      @(posedge clk); #1;
    end
    check("b_timeout", 32'(n < 50), 32'd1);
    if (n < 50) begin
      check("b_latency", n, 0);
      check("b_id", b_id, id);
      check("b_resp", b_resp, resp);
      @(posedge clk); #1;
    end
    b_ready = 1'b0;
    check("b_valid_after", b_valid, 0);
  endtask

  task automatic get_r(input logic [3:0] id, input logic [7:0] len, input int err_from,
                       input logic [31:0] e0, input logic [31:0] step);
    int n;
    r_ready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      for (n = 0; n < 50; n++) begin
        if (r_valid) break;
        @(posedge clk); #1;
      end
      check($sformatf("r_timeout[%0d]", i), 32'(n < 50), 32'd1);
      if (n >= 50) break;
      check($sformatf("r_gap[%0d]", i), n, 0);
      check($sformatf("r_id[%0d]", i), r_id, id);
      check($sformatf("r_data[%0d]", i), r_data, (i >= err_from) ? 32'h0 : e0 + 32'(i) * step);
      check($sformatf("r_resp[%0d]", i), r_resp, (i >= err_from) ? SLV : OKAY);
      check($sformatf("r_last[%0d]", i), r_last, i == int'(len));
      @(posedge clk); #1;
    end
    r_ready = 1'b0;
    check("r_valid_after", r_valid, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'h3, 32'h010, 8'd3, 3'd2, 2'd1, 4'hF, 32'hA0,       32'd1, 1'b0, OKAY, 256};
    vecs[1]  = '{1'b0, 4'h5, 32'h010, 8'd3, 3'd2, 2'd1, 4'hF, 32'hA0,       32'd1, 1'b0, OKAY, 256};
    vecs[2]  = '{1'b1, 4'h1, 32'h000, 8'd0, 3'd2, 2'd1, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b0, OKAY, 256};
    vecs[3]  = '{1'b1, 4'h2, 32'h000, 8'd0, 3'd2, 2'd1, 4'h5, 32'h12345678, 32'd0, 1'b0, OKAY, 256};
    vecs[4]  = '{1'b0, 4'h4, 32'h000, 8'd0, 3'd2, 2'd1, 4'hF, 32'hFF34FF78, 32'd0, 1'b0, OKAY, 256};
    vecs[5]  = '{1'b1, 4'h6, 32'h400, 8'd0, 3'd2, 2'd1, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0, SLV,  256};
    vecs[6]  = '{1'b0, 4'h7, 32'h010, 8'd1, 3'd2, 2'd2, 4'hF, 32'h0,        32'd0, 1'b0, OKAY, 0};
    vecs[7]  = '{1'b1, 4'h8, 32'h010, 8'd0, 3'd1, 2'd1, 4'hF, 32'h55,       32'd0, 1'b0, SLV,  256};
    vecs[8]  = '{1'b0, 4'h9, 32'h010, 8'd3, 3'd2, 2'd1, 4'hF, 32'hA0,       32'd1, 1'b0, OKAY, 256};
    vecs[9]  = '{1'b1, 4'hA, 32'h008, 8'd2, 3'd2, 2'd0, 4'hF, 32'h1,        32'd1, 1'b0, OKAY, 256};
    vecs[10] = '{1'b0, 4'hB, 32'h008, 8'd1, 3'd2, 2'd0, 4'hF, 32'h3,        32'd0, 1'b0, OKAY, 256};
    vecs[11] = '{1'b1, 4'hC, 32'h3F8, 8'd1, 3'd2, 2'd1, 4'hF, 32'h11,       32'd1, 1'b0, OKAY, 256};
    vecs[12] = '{1'b0, 4'hD, 32'h3F8, 8'd3, 3'd2, 2'd1, 4'hF, 32'h11,       32'd1, 1'b0, OKAY, 2};
    vecs[13] = '{1'b1, 4'hE, 32'h3FC, 8'd1, 3'd2, 2'd1, 4'hF, 32'h77,       32'd1, 1'b0, SLV,  256};
    vecs[14] = '{1'b1, 4'hF, 32'h020, 8'd1, 3'd2, 2'd1, 4'hF, 32'h5A0,      32'd1, 1'b1, SLV,  256};
    vecs[15] = '{1'b1, 4'h2, 32'h030, 8'd0, 3'd2, 2'd3, 4'hF, 32'h99,       32'd0, 1'b0, SLV,  256};
    vecs[16] = '{1'b0, 4'h1, 32'h400, 8'd0, 3'd2, 2'd1, 4'hF, 32'h0,        32'd0, 1'b0, OKAY, 0};
    vecs[17] = '{1'b0, 4'h0, 32'h000, 8'd0, 3'd2, 2'd1, 4'hF, 32'hFF34FF78, 32'd0, 1'b0, OKAY, 256};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_aw_ready", aw_ready, 0);
    check("rst_ar_ready", ar_ready, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_data", r_data, 0);
    check("rst_b_id", b_id, 0);
    check("rst_r_last", r_last, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_aw_ready", aw_ready, 1);
    check("idle_ar_ready", ar_ready, 1);

    // Simultaneous request after reset: write wins, read waits behind B
    aw_id = 4'h1; aw_addr = 32'h40; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'd1;
    ar_id = 4'h2; ar_addr = 32'h40; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'd1;
    aw_valid = 1'b1; ar_valid = 1'b1;
    #1;
    check("pair1_aw_ready", aw_ready, 1);
    check("pair1_ar_ready", ar_ready, 0);
    do_aw(4'h1, 32'h40, 8'd0, 3'd2, 2'd1);
    check("busy_ar_ready", ar_ready, 0);
    do_w(8'd0, 32'hCAFE0001, 32'd0, 4'hF, 1'b0);
    get_b(4'h1, OKAY);
    check("ar_ready_after_b", ar_ready, 1);
    do_ar(4'h2, 32'h40, 8'd0, 3'd2, 2'd1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_valid[%0d]", c), r_valid, 1);
      check($sformatf("stall_data[%0d]", c), r_data, 32'hCAFE0001);
      check($sformatf("stall_id[%0d]", c), r_id, 4'h2);
      check($sformatf("stall_last[%0d]", c), r_last, 1);
      check($sformatf("stall_resp[%0d]", c), r_resp, OKAY);
      @(posedge clk); #1;
    end
    get_r(4'h2, 8'd0, 256, 32'hCAFE0001, 32'd0);

    // A lone write flips priority back to read for the next contested pair
    do_aw(4'h3, 32'h44, 8'd0, 3'd2, 2'd1);
    do_w(8'd0, 32'hCAFE0002, 32'd0, 4'hF, 1'b0);
    get_b(4'h3, OKAY);
    aw_id = 4'h4; aw_addr = 32'h48; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'd1;
    ar_id = 4'h5; ar_addr = 32'h44; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'd1;
    aw_valid = 1'b1; ar_valid = 1'b1;
    #1;
    check("pair2_ar_ready", ar_ready, 1);
    check("pair2_aw_ready", aw_ready, 0);
    do_ar(4'h5, 32'h44, 8'd0, 3'd2, 2'd1);
    check("rdata_aw_ready", aw_ready, 0);
    get_r(4'h5, 8'd0, 256, 32'hCAFE0002, 32'd0);
    do_aw(4'h4, 32'h48, 8'd0, 3'd2, 2'd1);
    do_w(8'd0, 32'hCAFE0003, 32'd0, 4'hF, 1'b0);
    get_b(4'h4, OKAY);

    // Transaction table
    for (int v = 0; v < 18; v++) begin
      if (vecs[v].wr) begin
        do_aw(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
        do_w(vecs[v].len, vecs[v].d0, vecs[v].step, vecs[v].strb, vecs[v].bad_last);
        get_b(vecs[v].id, vecs[v].bresp);
      end else begin
        do_ar(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
        get_r(vecs[v].id, vecs[v].len, vecs[v].err_from, vecs[v].d0, vecs[v].step);
      end
    end

    // Reset pulse in the middle of an 8-beat read
    do_ar(4'h6, 32'h10, 8'd7, 3'd2, 2'd1);
    r_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_valid[%0d]", i), r_valid, 1);
      check($sformatf("abort_data[%0d]", i), r_data, 32'hA0 + 32'(i));
      @(posedge clk); #1;
    end
    r_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_r_valid", r_valid, 0);
    check("abort_r_data", r_data, 0);
    check("abort_ar_ready", ar_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_aw_ready", aw_ready, 1);
    check("post_ar_ready", ar_ready, 1);
    check("post_r_valid", r_valid, 0);
    check("post_b_valid", b_valid, 0);
    check("post_w_ready", w_ready, 0);
    do_ar(4'h7, 32'h10, 8'd3, 3'd2, 2'd1);
    get_r(4'h7, 8'd3, 256, 32'hA0, 32'd1);
    do_ar(4'h8, 32'h00, 8'd0, 3'd2, 2'd1);
    get_r(4'h8, 8'd0, 256, 32'hFF34FF78, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
